// File: rtl/move_merge_tiles_pkg.sv
// Shared sizes, board types and direction decoding for the 2048 move datapath.
package game2048_pkg;

    localparam int unsigned N       = 4;
    localparam int unsigned TILE_W  = 12;
    localparam int unsigned SCORE_W = 20;

    typedef logic [TILE_W-1:0]        tile_t;
    typedef tile_t [N-1:0][N-1:0]     board_t;
    typedef logic [SCORE_W-1:0]       score_t;
    typedef tile_t [N-1:0]            line_t;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam tile_t TILE_MAX = 12'h800;

    typedef enum logic [2:0] {
        MV_UP,
        MV_DOWN,
        MV_LEFT,
        MV_RIGHT,
        MV_NONE
    } move_t;

    // Anything other than exactly one set bit is treated as no move.
    function automatic move_t decode_dir(input logic [3:0] dir);
        unique case (dir)
            DIR_UP:    return MV_UP;
            DIR_DOWN:  return MV_DOWN;
            DIR_LEFT:  return MV_LEFT;
            DIR_RIGHT: return MV_RIGHT;
            default:   return MV_NONE;
        endcase
    endfunction

endpackage

// File: rtl/move_merge_tiles_line_merge.sv
// Combinational slide-and-merge of one 4-tile line, index 0 at the destination edge.
module line_merge
    import game2048_pkg::*;
(
    input  line_t  i_line,
    output line_t  o_line,
    output score_t o_score
);

    tile_t [N:0] w_ext;
    logic  [1:0] w_cnt;
    logic  [1:0] w_wr;
    logic        w_skip;
    tile_t       w_dbl;

    always_comb begin
        w_ext = '0;
        w_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_line[i] != '0) begin
                w_ext[w_cnt] = i_line[i];
                w_cnt        = w_cnt + 2'd1;
            end
        end
    end

    // w_ext[N] stays zero so the last tile never finds a merge partner.
    always_comb begin
        o_line  = '0;
        o_score = '0;
        w_wr    = '0;
        w_skip  = 1'b0;
        w_dbl   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_skip) begin
                w_skip = 1'b0;
            end else if (w_ext[i] != '0) begin
                if ((w_ext[i] == w_ext[i+1]) && (w_ext[i] < TILE_MAX)) begin
                    w_dbl        = {w_ext[i][TILE_W-2:0], 1'b0};
                    o_line[w_wr] = w_dbl;
                    o_score      = o_score + score_t'(w_dbl);
                    w_skip       = 1'b1;
                end else begin
                    o_line[w_wr] = w_ext[i];
                end
                w_wr = w_wr + 2'd1;
            end
        end
    end

endmodule

// File: rtl/move_merge_tiles.sv
// One 2048 move: gather lines by direction, merge each, scatter back, register result.
module move_merge_tiles
    import game2048_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] direction,
    input  board_t     board_in,
    output board_t     board_out,
    output score_t     score_update,
    output logic       moved,
    output logic       done
);

    move_t  w_move;
    board_t w_lines_in;
    board_t w_lines_out;
    score_t [N-1:0] w_line_score;
    board_t w_next;
    score_t w_score;
    logic   w_moved;

    board_t r_board;
    score_t r_score;
    logic   r_moved;
    logic   r_done;

    assign w_move = decode_dir(direction);

    always_comb begin
        w_lines_in = '0;
        for (int unsigned l = 0; l < N; l++) begin
            for (int unsigned k = 0; k < N; k++) begin
                unique case (w_move)
                    MV_UP:    w_lines_in[l][k] = board_in[k][l];
                    MV_DOWN:  w_lines_in[l][k] = board_in[N-1-k][l];
                    MV_LEFT:  w_lines_in[l][k] = board_in[l][k];
                    MV_RIGHT: w_lines_in[l][k] = board_in[l][N-1-k];
                    default:  w_lines_in[l][k] = board_in[l][k];
                endcase
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_line
        line_merge u_line_merge (
            .i_line  (w_lines_in[g]),
            .o_line  (w_lines_out[g]),
            .o_score (w_line_score[g])
        );
    end

    // Scatter is the exact inverse of the gather; an invalid direction passes the board through.
    always_comb begin
        w_next = board_in;
        for (int unsigned l = 0; l < N; l++) begin
            for (int unsigned k = 0; k < N; k++) begin
                unique case (w_move)
                    MV_UP:    w_next[k][l]     = w_lines_out[l][k];
                    MV_DOWN:  w_next[N-1-k][l] = w_lines_out[l][k];
                    MV_LEFT:  w_next[l][k]     = w_lines_out[l][k];
                    MV_RIGHT: w_next[l][N-1-k] = w_lines_out[l][k];
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        w_score = '0;
        if (w_move != MV_NONE) begin
            for (int unsigned l = 0; l < N; l++) begin
                w_score = w_score + w_line_score[l];
            end
        end
    end

    assign w_moved = (w_move != MV_NONE) && (w_next != board_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board <= '0;
            r_score <= '0;
            r_moved <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= start;
            if (start) begin
                r_board <= w_next;
                r_score <= w_score;
                r_moved <= w_moved;
            end
        end
    end

    assign board_out    = r_board;
    assign score_update = r_score;
    assign moved        = r_moved;
    assign done         = r_done;

endmodule

// File: tb/tb_move_merge_tiles.sv
// Table-driven bench with an expected-result queue popped on each done pulse.
module tb_move_merge_tiles;
    import game2048_pkg::*;

    typedef struct {
        logic [3:0] dir;
        board_t     b;
        board_t     exp_b;
        score_t     exp_s;
        logic       exp_m;
    } vec_t;

    typedef struct {
        board_t b;
        score_t s;
        logic   m;
    } exp_t;

    logic   clk;
    logic   rst_n;
    logic   start;
    logic   [3:0] direction;
    board_t board_in;
    board_t board_out;
    score_t score_update;
    logic   moved;
    logic   done;

    int     checks;
    int     errors;
    int     done_cnt;
    exp_t   exp_q[$];
    exp_t   hold;
    logic   exp_done;
    vec_t   vecs[12];

    move_merge_tiles u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .direction    (direction),
        .board_in     (board_in),
        .board_out    (board_out),
        .score_update (score_update),
        .moved        (moved),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic line_t rw(input tile_t c0, input tile_t c1, input tile_t c2, input tile_t c3);
        line_t r;
        r[0] = c0; r[1] = c1; r[2] = c2; r[3] = c3;
        return r;
    endfunction

    function automatic board_t bd(input line_t r0, input line_t r1, input line_t r2, input line_t r3);
        board_t b;
        b[0] = r0; b[1] = r1; b[2] = r2; b[3] = r3;
        return b;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        start     = 1'b1;
        direction = v.dir;
        board_in  = v.b;
        e.b = v.exp_b; e.s = v.exp_s; e.m = v.exp_m;
        exp_q.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_done <= 1'b0;
        else        exp_done <= start;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_board", board_out, '0);
            chk("rst_score", score_update, '0);
            chk("rst_moved", moved, '0);
            chk("rst_done", done, '0);
            hold = '{'0, '0, 1'b0};
        end else begin
            chk("done", done, exp_done);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual 1 required 0");
                end else begin
                    hold = exp_q.pop_front();
                    chk("board", board_out, hold.b);
                    chk("score", score_update, hold.s);
                    chk("moved", moved, hold.m);
                end
            end else begin
                chk("hold_board", board_out, hold.b);
                chk("hold_score", score_update, hold.s);
                chk("hold_moved", moved, hold.m);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        board_t z;
        board_t nb;
        int     d0;
        z  = '0;
        nb = bd(rw(0,0,0,0), rw(0,0,0,0), rw(2,4,2,4), rw(4,2,4,2));

        vecs[0]  = '{DIR_UP, bd(rw(2,2,4,4), rw(2,2,4,4), rw(0,0,4,0), rw(0,0,3,0)),
                     bd(rw(4,4,8,8), rw(0,0,4,0), rw(0,0,3,0), rw(0,0,0,0)), 20'h18, 1'b1};
        vecs[1]  = '{DIR_LEFT, bd(rw(2,2,2,2), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)),
                     bd(rw(4,4,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)), 20'd8, 1'b1};
        vecs[2]  = '{DIR_RIGHT, bd(rw(2,2,4,4), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)),
                     bd(rw(0,0,4,8), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)), 20'd12, 1'b1};
        vecs[3]  = '{DIR_DOWN, nb, nb, 20'd0, 1'b0};
        vecs[4]  = '{4'b0011, nb, nb, 20'd0, 1'b0};
        vecs[5]  = '{DIR_LEFT, bd(rw(12'h800,12'h800,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)),
                     bd(rw(12'h800,12'h800,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)), 20'd0, 1'b0};
        vecs[6]  = '{4'b0000, bd(rw(0,2,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)),
                     bd(rw(0,2,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)), 20'd0, 1'b0};
        vecs[7]  = '{DIR_RIGHT, bd(rw(0,0,0,0), rw(2,0,2,0), rw(0,0,0,0), rw(0,0,0,0)),
                     bd(rw(0,0,0,0), rw(0,0,0,4), rw(0,0,0,0), rw(0,0,0,0)), 20'd4, 1'b1};
        vecs[8]  = '{DIR_LEFT, bd(rw(0,0,0,0), rw(0,0,0,0), rw(3,3,3,0), rw(0,0,0,0)),
                     bd(rw(0,0,0,0), rw(0,0,0,0), rw(6,3,0,0), rw(0,0,0,0)), 20'd6, 1'b1};
        vecs[9]  = '{DIR_DOWN, bd(rw(0,2,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,2,0,0)),
                     bd(rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,4,0,0)), 20'd4, 1'b1};
        vecs[10] = '{DIR_LEFT, bd(rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(12'h400,12'h400,12'h800,12'h800)),
                     bd(rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(12'h800,12'h800,12'h800,0)), 20'h800, 1'b1};
        vecs[11] = '{DIR_UP, bd(rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,8)),
                     bd(rw(0,0,0,8), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0)), 20'd0, 1'b1};

        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        hold      = '{'0, '0, 1'b0};
        rst_n     = 1'b0;
        start     = 1'b0;
        direction = '0;
        board_in  = z;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(negedge clk);
            start = 1'b0;
        end

        // Three back-to-back starts must give three consecutive done cycles.
        @(negedge clk);
        d0 = done_cnt;
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        @(negedge clk);
        drive(vecs[2]);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_done_count", done_cnt - d0, 3);

        // Reset in the cycle after a start discards the pending result.
        start     = 1'b1;
        direction = DIR_UP;
        board_in  = vecs[0].b;
        @(posedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_board", board_out, '0);
        chk("async_rst_score", score_update, '0);
        chk("async_rst_moved", moved, '0);
        chk("async_rst_done", done, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        drive(vecs[8]);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        chk("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
